// File: rtl/fetch_ctrl.sv
// RV32 fetch sequencer: PC ownership, one-outstanding imem requests, redirect/kill.
// Optional misaligned-redirect fault pulse: define FETCH_CTRL_ALIGN_CHECK_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic        o_fetch_fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_st_n;
  logic [31:0] r_pc;
  logic [31:0] w_pc_n;
  logic [31:0] r_req_pc;
  logic [31:0] w_req_pc_n;
  logic        r_kill;
  logic        w_kill_n;
  logic [31:0] r_skid_instr;
  logic [31:0] w_skid_instr_n;
  logic [31:0] r_skid_pc;
  logic [31:0] w_skid_pc_n;
  logic        r_if_valid;
  logic        w_ifv_n;
  logic [31:0] r_if_instr;
  logic [31:0] w_if_instr_n;
  logic [31:0] r_if_pc;
  logic [31:0] w_if_pc_n;
  logic        w_req;
  logic        w_free;

  assign w_free      = ~r_if_valid | ~i_stall;
  assign w_req       = (r_state == S_REQ) & w_free;
  assign o_imem_req  = w_req;
  assign o_imem_addr = r_pc;
  assign o_if_valid  = r_if_valid;
  assign o_if_instr  = r_if_instr;
  assign o_if_pc     = r_if_pc;

  always_comb begin
    w_st_n         = r_state;
    w_pc_n         = r_pc;
    w_req_pc_n     = r_req_pc;
    w_kill_n       = r_kill;
    w_skid_instr_n = r_skid_instr;
    w_skid_pc_n    = r_skid_pc;
    w_ifv_n        = r_if_valid & i_stall;
    w_if_instr_n   = r_if_instr;
    w_if_pc_n      = r_if_pc;

    unique case (r_state)
      S_IDLE: w_st_n = S_REQ;
      S_REQ: begin
        if (w_req & i_imem_gnt) begin
          w_req_pc_n = r_pc;
          w_pc_n     = r_pc + 32'd4;
          w_st_n     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          if (r_kill) begin
            w_kill_n = 1'b0;
            w_st_n   = S_REQ;
          end else if (w_free) begin
            w_if_instr_n = i_imem_rdata;
            w_if_pc_n    = r_req_pc;
            w_ifv_n      = 1'b1;
            w_st_n       = S_REQ;
          end else begin
            w_skid_instr_n = i_imem_rdata;
            w_skid_pc_n    = r_req_pc;
            w_st_n         = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!i_stall) begin
          w_if_instr_n = r_skid_instr;
          w_if_pc_n    = r_skid_pc;
          w_ifv_n      = 1'b1;
          w_st_n       = S_REQ;
        end
      end
      default: w_st_n = S_IDLE;
    endcase

    // Redirect overrides everything; an in-flight grant becomes a kill.
    if (i_redirect_valid) begin
      w_pc_n  = {i_redirect_pc[31:2], 2'b00};
      w_ifv_n = 1'b0;
      unique case (r_state)
        S_REQ: begin
          if (w_req & i_imem_gnt) w_kill_n = 1'b1;
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            w_kill_n = 1'b0;
            w_st_n   = S_REQ;
          end else begin
            w_kill_n = 1'b1;
          end
        end
        S_HOLD: w_st_n = S_REQ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_kill       <= 1'b0;
      r_skid_instr <= 32'h0;
      r_skid_pc    <= 32'h0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= 32'h0;
      r_if_pc      <= 32'h0;
    end else begin
      r_state      <= w_st_n;
      r_pc         <= w_pc_n;
      r_req_pc     <= w_req_pc_n;
      r_kill       <= w_kill_n;
      r_skid_instr <= w_skid_instr_n;
      r_skid_pc    <= w_skid_pc_n;
      r_if_valid   <= w_ifv_n;
      r_if_instr   <= w_if_instr_n;
      r_if_pc      <= w_if_pc_n;
    end
  end

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
  logic r_fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= i_redirect_valid & (|i_redirect_pc[1:0]);
    end
  end

  assign o_fetch_fault = r_fault;
`else
  logic w_unused_lsb;

  assign w_unused_lsb  = ^i_redirect_pc[1:0];
  assign o_fetch_fault = 1'b0;
`endif

endmodule
